// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the four-way memory port arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int NREQ            = 4;
    localparam int IDX_W           = 2;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester-side and memory-port signals of the arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
    import arb_pkg::*;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] we;
    logic [31:0]     addr0, addr1, addr2, addr3;
    logic [31:0]     wdata0, wdata1, wdata2, wdata3;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic [31:0]     rdata;
    logic            timeout_err;
    logic            mem_valid;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic            mem_ready;
    logic [31:0]     mem_rdata;

    modport slave (
        input  req, we, addr0, addr1, addr2, addr3,
               wdata0, wdata1, wdata2, wdata3, mem_ready, mem_rdata,
        output grant, done, rdata, timeout_err,
               mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr0, addr1, addr2, addr3,
               wdata0, wdata1, wdata2, wdata3, mem_ready, mem_rdata,
        input  grant, done, rdata, timeout_err,
               mem_valid, mem_we, mem_addr, mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Round-robin winner search starting just after the last owner.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = last_i + IDX_W'(k);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux4.sv
// ============================================================================
// Module      : mux4
// Description : 4:1 selector of parameterised width.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mux4 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    input  logic [WIDTH-1:0] d3_i,
    input  logic [1:0]       sel_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin sequencer sharing one 32-bit memory port among four masters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             busy;

    rr_pick u_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    mux4 #(.WIDTH(32)) u_addr_mux (
        .d0_i  (bus.addr0),
        .d1_i  (bus.addr1),
        .d2_i  (bus.addr2),
        .d3_i  (bus.addr3),
        .sel_i (owner_q),
        .y_o   (sel_addr)
    );

    mux4 #(.WIDTH(32)) u_wdata_mux (
        .d0_i  (bus.wdata0),
        .d1_i  (bus.wdata1),
        .d2_i  (bus.wdata2),
        .d3_i  (bus.wdata3),
        .sel_i (owner_q),
        .y_o   (sel_wdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            owner_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // A ready on the final budget cycle still counts as a normal completion.
                if (bus.mem_ready) begin
                    rdata_d = bus.mem_rdata;
                    err_d   = 1'b0;
                    last_d  = owner_q;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    last_d  = owner_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy            = (state_q == BUSY);
    assign bus.grant       = busy ? idx_onehot(owner_q) : '0;
    assign bus.done        = (state_q == DONE) ? idx_onehot(owner_q) : '0;
    assign bus.timeout_err = (state_q == DONE) & err_q;
    assign bus.rdata       = rdata_q;
    assign bus.mem_valid   = busy;
    assign bus.mem_we      = busy & bus.we[owner_q];
    assign bus.mem_addr    = busy ? sel_addr : '0;
    assign bus.mem_wdata   = busy ? sel_wdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for the round-robin memory port arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    import arb_pkg::*;

    localparam int TO = 15;

    typedef struct {
        int          owner;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rdata;
        logic        err;
        int          busy;
    } exp_t;

    logic        clock;
    logic        reset;
    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [3:0]  pending;
    int          last_m;
    logic [31:0] addr_a[4];
    logic [31:0] wdata_a[4];
    logic [3:0]  we_r;
    longint      cyc = 0;
    bit          spacing_on = 0;

    mem_port_arbiter_if bus();

    assign bus.addr0  = addr_a[0];
    assign bus.addr1  = addr_a[1];
    assign bus.addr2  = addr_a[2];
    assign bus.addr3  = addr_a[3];
    assign bus.wdata0 = wdata_a[0];
    assign bus.wdata1 = wdata_a[1];
    assign bus.wdata2 = wdata_a[2];
    assign bus.wdata3 = wdata_a[3];
    assign bus.we     = we_r;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: peeks the oldest expectation while the port is busy, pops it on done.
    initial begin
        exp_t   e;
        int     busy_cnt = 0;
        longint prev_done = -1;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (!reset) begin
                busy_cnt = 0;
                continue;
            end
            if (!spacing_on) prev_done = -1;
            if (bus.mem_valid) begin
                busy_cnt++;
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    e = sbq[0];
                    chk("grant", 64'(bus.grant), 64'(4'b0001 << e.owner));
                    chk("mem_we", 64'(bus.mem_we), 64'(e.we));
                    chk("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
                    chk("mem_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
                    chk("done_in_busy", 64'(bus.done), 64'd0);
                end
            end else begin
                chk("grant_idle", 64'(bus.grant), 64'd0);
            end
            if (bus.done != 4'd0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("done", 64'(bus.done), 64'(4'b0001 << e.owner));
                    chk("rdata", 64'(bus.rdata), 64'(e.rdata));
                    chk("timeout_err", 64'(bus.timeout_err), 64'(e.err));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
                    if (spacing_on && prev_done >= 0)
                        chk("spacing", 64'(cyc - prev_done), 64'd3);
                    prev_done = cyc;
                end
                busy_cnt = 0;
            end else begin
                chk("timeout_err_quiet", 64'(bus.timeout_err), 64'd0);
            end
        end
    end

    // One transaction: add requests, predict the winner, serve the port with latency lat.
    // lat > TO means mem_ready never comes; reset_at > 0 asserts reset in that BUSY cycle.
    task automatic run_txn(input logic [3:0] add, input int lat, input logic [31:0] rd,
                           input bit keep, input bit rnd_data, input bit drop, input int reset_at);
        exp_t e;
        int   own;
        int   c;
        int   guard;
        pending = pending | add;
        if (pending == 4'd0) pending = 4'b0001;
        if (rnd_data) begin
            for (int i = 0; i < 4; i++) begin
                addr_a[i]  = $urandom;
                wdata_a[i] = $urandom;
            end
            we_r = 4'($urandom_range(0, 15));
        end
        own = -1;
        for (int k = 1; k <= 4; k++) begin
            if (own < 0 && pending[(last_m + k) % 4]) own = (last_m + k) % 4;
        end
        last_m   = own;
        e.owner  = own;
        e.addr   = addr_a[own];
        e.wdata  = wdata_a[own];
        e.we     = we_r[own];
        e.err    = (lat > TO);
        e.rdata  = (lat > TO) ? 32'd0 : rd;
        e.busy   = (lat > TO) ? TO : lat;
        sbq.push_back(e);
        bus.req = pending;

        guard = 0;
        while (!bus.mem_valid && guard < 6) begin
            @(negedge clock);
            guard++;
        end
        if (!bus.mem_valid) begin
            chk("no_grant", 64'd0, 64'd1);
            void'(sbq.pop_back());
            return;
        end
        c = 1;
        while (bus.mem_valid && c <= TO + 5) begin
            if (reset_at == c) begin
                reset = 1'b0;
                bus.mem_ready = 1'b0;
                #1;
                chk("rst_grant", 64'(bus.grant), 64'd0);
                chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
                chk("rst_done", 64'(bus.done), 64'd0);
                chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
                void'(sbq.pop_back());
                last_m  = 3;
                pending = 4'd0;
                bus.req = 4'd0;
                repeat (2) @(negedge clock);
                reset = 1'b1;
                return;
            end
            if (c == lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rd;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
            end
            if (drop && c == 1) begin
                pending[own] = 1'b0;
                bus.req = pending;
            end
            @(negedge clock);
            c++;
        end
        bus.mem_ready = 1'b0;
        if (bus.mem_valid) chk("busy_overrun", 64'd1, 64'd0);
        pending[own] = keep;
        bus.req = pending;
    endtask

    initial begin
        int lat;
        reset         = 1'b0;
        bus.req       = 4'd0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        we_r          = 4'd0;
        pending       = 4'd0;
        last_m        = 3;
        for (int i = 0; i < 4; i++) begin
            addr_a[i]  = 32'h1000 * (i + 1);
            wdata_a[i] = 32'hA000 + i;
        end
        repeat (2) @(negedge clock);
        chk("reset_grant", 64'(bus.grant), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_rdata", 64'(bus.rdata), 64'd0);
        chk("reset_timeout_err", 64'(bus.timeout_err), 64'd0);
        chk("reset_mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("reset_mem_we", 64'(bus.mem_we), 64'd0);
        chk("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("reset_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Single read from requester 2
        addr_a[2] = 32'h100;
        run_txn(4'b0100, 2, 32'hDEADBEEF, 0, 0, 0, 0);

        // Write steering from requester 1
        addr_a[1]  = 32'h40;
        wdata_a[1] = 32'h12345678;
        we_r       = 4'b0010;
        run_txn(4'b0010, 1, 32'h0BADF00D, 0, 0, 0, 0);

        // Timeout, then normal service, then ready on the final budget cycle
        run_txn(4'b0001, TO + 10, 32'h55AA55AA, 0, 1, 0, 0);
        run_txn(4'b0100, 3, 32'hCAFEF00D, 0, 1, 0, 0);
        run_txn(4'b1000, TO, 32'h13579BDF, 0, 1, 0, 0);

        // Reset mid-BUSY, then requester 0 wins over 3
        run_txn(4'b0010, TO + 10, 32'h0, 0, 1, 0, 3);
        run_txn(4'b1001, 1, 32'h11111111, 0, 1, 0, 0);
        run_txn(4'b0000, 1, 32'h33333333, 0, 1, 0, 0);

        // Fairness with all requests held and immediate ready
        spacing_on = 1;
        for (int n = 0; n < 5; n++) run_txn(4'b1111, 1, $urandom, 1, 1, 0, 0);
        spacing_on = 0;

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) lat = $urandom_range(TO - 2, TO + 3);
            else lat = $urandom_range(1, 4);
            run_txn(4'($urandom_range(0, 15)), lat, $urandom,
                    1'($urandom_range(0, 1)), 1, ($urandom_range(0, 7) == 0), 0);
        end
        pending = 4'd0;
        bus.req = 4'd0;

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and sequencer that shares one 32-bit memory port among four requesters: instruction fetch, data load/store, and two auxiliary masters. It sits between the processor masters and the single-ported memory. It grants one requester at a time and steers that requester's address and write data onto the port using the existing 4:1 32-bit selector. It returns read data and a completion pulse to the owner, and aborts transactions that exceed a cycle budget.

## Interface
- `TIMEOUT`, 15: maximum BUSY cycles without `mem_ready` before abort (1..255)
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset asserted)
- `req`  in  4  per-requester request; hold high until `done` for that requester
- `we`  in  4  per-requester write enable; sampled with its request
- `addr0`..`addr3`  in  32 each  requester addresses
- `wdata0`..`wdata3`  in  32 each  requester write data
- `grant`  out  4  one-hot owner indication; all-zero when no owner
- `done`  out  4  one-cycle completion pulse to the owner
- `rdata`  out  32  registered read data, broadcast to all requesters, valid while `done` is high
- `timeout_err`  out  1  high with `done` when the transaction was aborted
- `mem_valid`  out  1  port request
- `mem_we`  out  1  port write enable
- `mem_addr`, `mem_wdata`  out  32 each  selected owner's address and write data
- `mem_ready`  in  1  port completion; `mem_rdata` valid in the same cycle
- `mem_rdata`  in  32  port read data

## Operation
- FSM states:
  - IDLE: if any `req` is high, pick the winner, register the owner index, go to BUSY.
  - BUSY: hold `mem_valid`=1. On `mem_ready`=1, capture `mem_rdata` and go to DONE. If the counter reaches `TIMEOUT`, load `rdata`=0, set the error flag, go to DONE.
  - DONE: pulse `done[owner]`, drive `timeout_err`, go to IDLE.
- Round-robin pointer `last`, reset value 3:
  - Search order is `last`+1, `last`+2, ... modulo 4, so requester 0 wins first after reset.
  - `last` is updated to the owner on entry to DONE.
- `grant` is one-hot of the owner in BUSY only; it is 0 in IDLE and DONE.
- `mem_addr` and `mem_wdata` come from the selected `addrN`/`wdataN`.
- `mem_we` = `we[owner]` in BUSY, otherwise 0. `mem_addr`/`mem_wdata` are don't-care outside BUSY.
- Owner inputs must stay stable during BUSY. The arbiter does not re-check `req` in BUSY: if `req[owner]` drops mid-transaction, the transaction still completes and `done` still pulses.
- Timeout counter:
  - Width is the bits needed for `TIMEOUT`; cleared on entry to BUSY; increments each BUSY cycle.
  - Abort fires in the cycle where count = `TIMEOUT`-1 and `mem_ready`=0.
  - `mem_ready` wins if both occur in the same cycle.
- Write transactions: `rdata` is loaded with `mem_rdata` anyway; the value is meaningless.

## Timing
- Reset values (while `reset`=0, asynchronously): state IDLE, `last`=3, counter 0, owner 0, and all outputs 0 (`grant`, `done`, `rdata`, `timeout_err`, `mem_valid`, `mem_we`, `mem_addr`, `mem_wdata`).
- Latency:
  - `req` high at edge t (IDLE) → `grant`/`mem_valid` high from t+1.
  - `mem_ready` sampled at edge k → `done`/`rdata` valid in cycle k+1 → back in IDLE at k+2.
  - Minimum transaction is 3 cycles: IDLE → BUSY(1) → DONE.
- A requester may drop `req` in its DONE cycle. If it holds `req`, it competes again in IDLE but ranks last.
- Reset asserted mid-BUSY: the transaction is abandoned with no `done` pulse, and `mem_valid` drops immediately.
- `req` arriving during BUSY or DONE is held by the requester and considered in the next IDLE.

## Structure
- Package `arb_pkg`:
  - `NREQ`=4 and `IDX_W`=2
  - state enum {IDLE, BUSY, DONE}
  - default `TIMEOUT`
- Sub-module `rr_pick`: combinational, takes `req`[3:0] and `last`[1:0], returns `any` and `idx`[1:0].
- The data steering instantiates the existing 32-bit `mux4` twice, once for address and once for write data, with the registered owner as the select.

## Test plan
- Single read: after reset, `req`=0100 with `addr2`=0x100; `mem_ready` on the 2nd BUSY cycle with `mem_rdata`=0xDEADBEEF → `grant`=0100 for 2 cycles, then `done`=0100 with `rdata`=0xDEADBEEF, `timeout_err`=0.
- Fairness: `req`=1111 held continuously, `mem_ready` always 1 → grant order 0001, 0010, 0100, 1000, 0001, with one transaction every 3 cycles.
- Write steering: `req`=0010, `we`=0010, `wdata1`=0x12345678, `addr1`=0x40 → in BUSY `mem_we`=1, `mem_addr`=0x40, `mem_wdata`=0x12345678; no other requester's values appear on the port.
- Timeout: `TIMEOUT`=15, `mem_ready` held 0 → exactly 15 BUSY cycles, then `done`=owner with `timeout_err`=1 and `rdata`=0; the next request is served normally.
- Same-cycle `mem_ready` and timeout: `mem_ready`=1 in the 15th BUSY cycle → normal completion with `timeout_err`=0.
- Reset mid-BUSY: drive `reset`=0 while granted → `grant`, `mem_valid` and `done` go to 0 immediately; after release, `req`=1001 → requester 0 wins.
